// File: rtl/led_code_scheduler.sv
// Shares one user LED among NREQ requesters: round-robin grant, blink code of k pulses, quiet gap, ACK.
// Optional IDLE heartbeat on the LED when LED_CODE_SCHEDULER_HEARTBEAT_EN is defined.
module led_code_scheduler #(
    parameter int CLK_HZ    = 16000000,
    parameter int TICK_HZ   = 1000,
    parameter int NREQ      = 4,
    parameter int ON_TICKS  = 200,
    parameter int OFF_TICKS = 200,
    parameter int GAP_TICKS = 1000,
    localparam int ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ,
    input  logic [4*NREQ-1:0] CODE,
    output logic [NREQ-1:0]   ACK,
    output logic [ID_W-1:0]   GNT_ID,
    output logic              BUSY,
    output logic              LED
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PS_W  = $clog2(DIV);
    localparam int MAX_T = (ON_TICKS > OFF_TICKS)
                         ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                         : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int PH_W  = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t          state;
    logic [PS_W-1:0] ps;
    logic [PH_W-1:0] ph;
    logic [3:0]      pulses;
    logic [ID_W-1:0] ptr;
    logic            tick;

    logic [3:0]      code_arr [NREQ];
    logic [NREQ-1:0] elig;
    logic            found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic [3:0]      win_code;

`ifdef LED_CODE_SCHEDULER_HEARTBEAT_EN
    localparam int HB_HALF = TICK_HZ / 2;
    localparam int HB_W    = $clog2(HB_HALF + 1);
    logic [HB_W-1:0] hb_cnt;
    logic            hb_lvl;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_code
        assign code_arr[g] = CODE[4*g +: 4];
    end

    assign tick = (ps == PS_W'(DIV - 1));
    // A requester whose ACK is high this cycle is not eligible again yet.
    assign elig = REQ & ~ACK;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = ID_W'((int'(ptr) + off) % NREQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_code = code_arr[win];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            LED    <= 1'b0;
            ACK    <= '0;
            BUSY   <= 1'b0;
            GNT_ID <= '0;
            ps     <= '0;
            ph     <= '0;
            pulses <= '0;
            ptr    <= ID_W'(NREQ - 1);
`ifdef LED_CODE_SCHEDULER_HEARTBEAT_EN
            hb_cnt <= '0;
            hb_lvl <= 1'b1;
`endif
        end else begin
            ACK <= '0;
            ps  <= tick ? '0 : ps + 1'b1;
            case (state)
                IDLE: begin
                    if (found) begin
                        // Restart the prescaler so every phase is a whole number of ticks.
                        GNT_ID <= win;
                        ptr    <= win;
                        BUSY   <= 1'b1;
                        ps     <= '0;
                        ph     <= '0;
                        pulses <= win_code;
                        if (win_code != 4'd0) begin
                            state <= ON;
                            LED   <= 1'b1;
                        end else begin
                            state <= GAP;
                            LED   <= 1'b0;
                        end
`ifdef LED_CODE_SCHEDULER_HEARTBEAT_EN
                        hb_cnt <= '0;
                        hb_lvl <= 1'b1;
`endif
                    end
`ifdef LED_CODE_SCHEDULER_HEARTBEAT_EN
                    else begin
                        LED <= hb_lvl;
                        if (tick) begin
                            if (hb_cnt == HB_W'(HB_HALF - 1)) begin
                                hb_cnt <= '0;
                                hb_lvl <= ~hb_lvl;
                            end else begin
                                hb_cnt <= hb_cnt + 1'b1;
                            end
                        end
                    end
`endif
                end
                ON: begin
                    if (tick) begin
                        if (ph == PH_W'(ON_TICKS - 1)) begin
                            ph    <= '0;
                            state <= OFF;
                            LED   <= 1'b0;
                        end else begin
                            ph <= ph + 1'b1;
                        end
                    end
                end
                OFF: begin
                    if (tick) begin
                        if (ph == PH_W'(OFF_TICKS - 1)) begin
                            ph     <= '0;
                            pulses <= pulses - 4'd1;
                            if (pulses > 4'd1) begin
                                state <= ON;
                                LED   <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            ph <= ph + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (ph == PH_W'(GAP_TICKS - 1)) begin
                            ph          <= '0;
                            ACK[GNT_ID] <= 1'b1;
                            BUSY        <= 1'b0;
                            LED         <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            ph <= ph + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_code_scheduler.sv
// Scoreboard bench for led_code_scheduler at CLK_HZ=100, TICK_HZ=10 (DIV=10), ON=2, OFF=2, GAP=5 ticks.
module tb_led_code_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] code = '0;
    logic [3:0]  ack;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        led;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { int id; bit b2b; } gnt_t;
    typedef struct { int id; int lat; } ack_t;
    gnt_t exp_gnt_q[$];
    ack_t exp_ack_q[$];
    int   gnt_cyc = 0;
    int   last_ack_cyc = -10;
    logic busy_q = 1'b0;

    led_code_scheduler #(
        .CLK_HZ(100), .TICK_HZ(10), .NREQ(4),
        .ON_TICKS(2), .OFF_TICKS(2), .GAP_TICKS(5)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .REQ(req), .CODE(code),
        .ACK(ack), .GNT_ID(gnt_id), .BUSY(busy), .LED(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: grant id / back-to-back spacing, and ACK id / latency from grant.
    always @(negedge clk) begin
        gnt_t g;
        ack_t a;
        logic [3:0] m;
        if (rst_n && busy && !busy_q) begin
            checks++;
            if (exp_gnt_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant got=%0d exp=none", gnt_id);
            end else begin
                g = exp_gnt_q.pop_front();
                if (gnt_id !== 2'(g.id)) begin
                    errors++;
                    $display("FAIL grant_id got=%0d exp=%0d", gnt_id, g.id);
                end
                if (g.b2b) begin
                    checks++;
                    if (cyc != last_ack_cyc + 1) begin
                        errors++;
                        $display("FAIL grant_spacing got=%0d exp=%0d", cyc - last_ack_cyc, 1);
                    end
                end
            end
            gnt_cyc = cyc;
        end
        if (ack !== 4'b0000) begin
            checks++;
            if (exp_ack_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack got=%b exp=0000", ack);
            end else begin
                a = exp_ack_q.pop_front();
                m = 4'(1 << a.id);
                if (ack !== m) begin
                    errors++;
                    $display("FAIL ack_id got=%b exp=%b", ack, m);
                end
                checks++;
                if (cyc - gnt_cyc != a.lat) begin
                    errors++;
                    $display("FAIL ack_latency got=%0d exp=%0d", cyc - gnt_cyc, a.lat);
                end
            end
            last_ack_cyc = cyc;
        end
        busy_q = busy;
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got=%b exp=0", led); end
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt got=%0d exp=0", gnt_id); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_code2();
        bit ok;
        logic exp_led;
        exp_gnt_q.push_back('{0, 1'b0});
        exp_ack_q.push_back('{0, 130});
        code = 16'h0002;
        req  = 4'b0001;
        wait_busy(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_grant got=timeout exp=busy"); end
        for (int t = 0; t < 130; t++) begin
            exp_led = (t < 20) || (t >= 40 && t < 60);
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL single_led t=%0d got=%b exp=%b", t, led, exp_led); end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL single_busy t=%0d got=%b exp=1", t, busy); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b exp=0001", ack); end
        req = 4'b0000;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_ack_q.size() != 0) begin errors++; $display("FAIL single_drain got=%0d exp=0", exp_ack_q.size()); end
    endtask

    task automatic test_round_robin();
        bit done;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_gnt_q.push_back('{i, (i != 0)});
            exp_ack_q.push_back('{i, 90});
        end
        code = 16'h1111;
        req  = 4'b1111;
        done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ack !== 4'b0000) req = req & ~ack;
            if (req == 4'b0000 && busy === 1'b0 && exp_ack_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done || exp_gnt_q.size() != 0) begin
            errors++;
            $display("FAIL rr_complete got=%0d pending exp=0", exp_ack_q.size() + exp_gnt_q.size());
        end
    endtask

    task automatic test_zero_code();
        bit ok;
        exp_gnt_q.push_back('{2, 1'b0});
        exp_ack_q.push_back('{2, 50});
        code = 16'h5055;
        req  = 4'b0100;
        wait_busy(ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_grant got=timeout exp=busy"); end
        for (int t = 0; t < 50; t++) begin
            checks++;
            if (led !== 1'b0) begin errors++; $display("FAIL zero_led t=%0d got=%b exp=0", t, led); end
            @(negedge clk);
        end
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL zero_ack got=%b exp=0100", ack); end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop_req();
        bit ok;
        int pulses;
        logic prev;
        exp_gnt_q.push_back('{1, 1'b0});
        exp_ack_q.push_back('{1, 170});
        code = 16'h0030;
        req  = 4'b0010;
        wait_busy(ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_grant got=timeout exp=busy"); end
        pulses = 0;
        prev = 1'b0;
        for (int t = 0; t < 170; t++) begin
            if (t == 5) begin
                req  = 4'b0000;
                code = 16'h00F0;
            end
            if (led === 1'b1 && prev === 1'b0) pulses++;
            prev = led;
            @(negedge clk);
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL drop_pulses got=%0d exp=3", pulses); end
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL drop_ack got=%b exp=0010", ack); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_on();
        bit ok;
        bit done;
        apply_reset();
        exp_gnt_q.push_back('{0, 1'b0});
        code = 16'h0011;
        req  = 4'b0011;
        wait_busy(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_grant got=timeout exp=busy"); end
        repeat (10) @(negedge clk);
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL midrst_on got=%b exp=1", led); end
        exp_ack_q.delete();
        exp_gnt_q.push_back('{0, 1'b0});
        exp_ack_q.push_back('{0, 90});
        exp_gnt_q.push_back('{1, 1'b1});
        exp_ack_q.push_back('{1, 90});
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL midrst_led got=%b exp=0", led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (ack !== 4'b0) begin errors++; $display("FAIL midrst_ack got=%b exp=0000", ack); end
        rst_n = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ack !== 4'b0000) req = req & ~ack;
            if (req == 4'b0000 && busy === 1'b0 && exp_ack_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done || exp_gnt_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_complete got=%0d pending exp=0", exp_ack_q.size() + exp_gnt_q.size());
        end
    endtask

`ifdef LED_CODE_SCHEDULER_HEARTBEAT_EN
    task automatic test_heartbeat();
        bit ok;
        int n;
        logic prev;
        apply_reset();
        req = 4'b0000;
        prev = led;
        n = 0;
        while (led === prev && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            prev = led;
            n = 0;
            while (led === prev && n < 200) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != 50) begin errors++; $display("FAIL hb_period k=%0d got=%0d exp=50", k, n); end
        end
        exp_gnt_q.push_back('{0, 1'b0});
        exp_ack_q.push_back('{0, 90});
        code = 16'h0001;
        req  = 4'b0001;
        wait_busy(ok);
        checks++; if (!ok) begin errors++; $display("FAIL hb_grant got=timeout exp=busy"); end
        for (int t = 0; t < 90; t++) begin
            checks++;
            if (led !== (t < 20)) begin errors++; $display("FAIL hb_pulse t=%0d got=%b exp=%b", t, led, (t < 20)); end
            @(negedge clk);
        end
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL hb_ack got=%b exp=0001", ack); end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_code2();
        test_round_robin();
        test_zero_code();
        test_drop_req();
        test_reset_mid_on();
`ifdef LED_CODE_SCHEDULER_HEARTBEAT_EN
        test_heartbeat();
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (exp_ack_q.size() != 0 || exp_gnt_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain got=%0d exp=0", exp_ack_q.size() + exp_gnt_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_code_scheduler.md
Name: led_code_scheduler

Overview:
- Shares the board's single user LED among NREQ requesters. Each requester asks for a blink code of 1..15 pulses.
- Round-robin arbitration picks one requester. The block plays that requester's code as ON/OFF pulses followed by a quiet gap, then acknowledges it.
- Sits between status-producing logic (error flags, boot stages) and the LED pin. Tick timing is derived from the 16 MHz board clock.

Parameters:
- CLK_HZ, 16000000: input clock frequency in Hz.
- TICK_HZ, 1000: timebase tick rate. DIV = CLK_HZ/TICK_HZ; integer division required, DIV >= 2.
- NREQ, 4: number of requesters, 2..8.
- ON_TICKS, 200: LED-on duration of one pulse, in ticks, >= 1.
- OFF_TICKS, 200: LED-off duration after each pulse, in ticks, >= 1.
- GAP_TICKS, 1000: quiet time after the last pulse before ACK, in ticks, >= 1.

Ports:
- CLK, input, 1: board clock. All logic is on the rising edge.
- RST_N, input, 1: reset, synchronous and active-low.
- REQ, input, NREQ: level request per requester.
- CODE, input, 4*NREQ: pulse count for requester i, at CODE[4i+3:4i].
- ACK, output, NREQ: one-cycle completion pulse per requester.
- GNT_ID, output, clog2(NREQ) (min 1): index of the requester currently being played.
- BUSY, output, 1: high while a code is being played.
- LED, output, 1: LED drive, registered.

Behaviour:
- Reset (RST_N=0 at an edge): state=IDLE, LED=0, ACK=0, BUSY=0, GNT_ID=0, prescaler=0, phase counter=0, pulse counter=0, RR pointer=NREQ-1 (so requester 0 wins first).
- Reset mid-play aborts immediately. No ACK is issued for the aborted request.
- Prescaler: counts 0..DIV-1 and wraps. tick=1 when count==DIV-1. Free-running in IDLE. Forced to 0 on the grant edge, so phase lengths are exact multiples of DIV cycles.
- States: IDLE, ON, OFF, GAP.
- IDLE arbitration:
  - Eligible requester = REQ[i]=1 and ACK[i]=0 in the current cycle. A requester must drop REQ on the cycle it sees ACK.
  - Search order is pointer+1, pointer+2, ... modulo NREQ. The first eligible requester wins.
  - At grant edge E0: GNT_ID<=i, pointer<=i, latch code k=CODE[i], BUSY<=1.
  - k>=1: state<=ON, LED<=1, pulse counter<=k.
  - k=0: no pulses. State goes straight to GAP, LED stays 0.
- ON: LED=1 for exactly ON_TICKS*DIV cycles, then go to OFF with LED<=0.
- OFF: LED=0 for OFF_TICKS*DIV cycles. Pulse counter decrements on OFF exit. If it is still >0, go to ON; otherwise go to GAP.
- GAP: LED=0 for GAP_TICKS*DIV cycles. On exit: ACK[GNT_ID]<=1 for one cycle, BUSY<=0, state<=IDLE.
- Earliest next grant is the edge after the ACK cycle. GNT_ID holds its last value while IDLE.
- Total latency from E0 to the ACK cycle: (k*(ON_TICKS+OFF_TICKS) + GAP_TICKS)*DIV cycles.
- Latched request: REQ or CODE changes after grant are ignored until ACK; a dropped REQ still completes and ACKs. CODE is sampled only at the grant edge.
- Simultaneous requests: round-robin only. No requester is granted twice while another eligible requester waits.
- Counter widths: sized from the max of ON_TICKS, OFF_TICKS and GAP_TICKS, and from DIV. No wrap inside a phase.

Optional Feature:
- Macro: LED_CODE_SCHEDULER_HEARTBEAT_EN.
- Defined: in IDLE, LED shows a heartbeat that is high for TICK_HZ/2 ticks and low for TICK_HZ/2 ticks (1 Hz at defaults).
  - Heartbeat counter runs only in IDLE and resets to 0 on each grant.
  - LED is 0 on the first IDLE cycle after ACK, then follows the heartbeat.
- Undefined: LED=0 whenever IDLE. No heartbeat logic is synthesised.

Test Plan (CLK_HZ=100, TICK_HZ=10 so DIV=10, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=5, NREQ=4, macro undefined unless noted):
- REQ=0001, CODE0=2 -> LED high 20, low 20, high 20, low 70 cycles after grant edge. ACK[0] is one cycle at E0+130. BUSY is high for E0..E0+129.
- REQ=1111, all codes 1, each requester drops REQ on its ACK -> grant order 0,1,2,3. Each ACK comes 90 cycles after its grant; consecutive grants are 91 cycles apart.
- REQ=0100, CODE2=0 -> LED stays 0. ACK[2] at E0+50.
- Requester 1 drops REQ 5 cycles after grant, CODE1=3 -> all 3 pulses still play. ACK[1] at E0+170.
- RST_N=0 for one edge mid-ON -> LED=0, BUSY=0, no ACK. Requester 0 is granted first again afterwards.
- LED_CODE_SCHEDULER_HEARTBEAT_EN defined, REQ=0 -> LED toggles every 50 cycles. Grant with CODE=1 -> pulse plays exactly as without the macro.
